lsu_bus_ctrl: RTL

Load/store unit sitting between the execute stage and the data bus. It turns a load/store request (address, funct3, store data) into a single Wishbone-classic bus cycle with byte lanes. On loads it aligns and sign/zero-extends the returned word and produces the memory data consumed by writeback. It stalls the pipeline while a transfer is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_bus_ctrl_if.sv | 39 +++
 rtl/lsu_bus_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | lsu_bus_ctrl_if                                                     |
// | Request/response and Wishbone-classic signal bundle for the LSU.    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
interface lsu_bus_ctrl_if;
  logic        req_valid_i;
  logic        req_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] mem_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  // master = the LSU (it masters the data bus); slave = EX stage plus bus target
  modport master (
    input  req_valid_i, req_we_i, funct3_i, addr_i, wdata_i, bus_dat_i, bus_ack_i,
    output busy_o, done_o, err_o, mem_o,
           bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, funct3_i, addr_i, wdata_i, bus_dat_i, bus_ack_i,
    input  busy_o, done_o, err_o, mem_o,
           bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | lsu_bus_ctrl                                                        |
// | Load/store unit issuing one Wishbone-classic cycle per request,     |
// | with byte lanes, load extension, misalign and timeout detection.    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input wire             clk_i,
  input wire             rst_i,
  lsu_bus_ctrl_if.master lsu
);

  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_BUS     = 1'b1;
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic        r_cyc;
  logic        r_we;
  logic [31:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_mem;

  logic        w_legal;
  logic        w_aligned;
  logic [3:0]  w_sel;
  logic [31:0] w_dat;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode: legality, alignment and lane placement
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_sel     = 4'b1111;
    w_dat     = lsu.wdata_i;
    case (lsu.funct3_i)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~lsu.req_we_i;
      default:                w_legal = 1'b0;
    endcase
    case (lsu.funct3_i[1:0])
      2'b00: begin
        w_sel = 4'b0001 << lsu.addr_i[1:0];
        w_dat = {4{lsu.wdata_i[7:0]}};
      end
      2'b01: begin
        w_aligned = ~lsu.addr_i[0];
        w_sel     = 4'b0011 << {lsu.addr_i[1], 1'b0};
        w_dat     = {2{lsu.wdata_i[15:0]}};
      end
      default: w_aligned = (lsu.addr_i[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = lsu.bus_dat_i[7:0];
      2'd1:    w_byte = lsu.bus_dat_i[15:8];
      2'd2:    w_byte = lsu.bus_dat_i[23:16];
      default: w_byte = lsu.bus_dat_i[31:24];
    endcase
    w_half = r_off[1] ? lsu.bus_dat_i[31:16] : lsu.bus_dat_i[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = lsu.bus_dat_i;
    endcase
  end

  // BUS also covers the done/err pulse cycle (r_cyc low), keeping busy_o up through it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 32'd0;
      r_sel   <= 4'd0;
      r_dat   <= 32'd0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_cnt   <= 8'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_mem   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (lsu.req_valid_i) begin
            if (w_legal && w_aligned) begin
              r_state <= c_BUS;
              r_cyc   <= 1'b1;
              r_we    <= lsu.req_we_i;
              r_adr   <= {lsu.addr_i[31:2], 2'b00};
              r_sel   <= w_sel;
              r_dat   <= lsu.req_we_i ? w_dat : 32'd0;
              r_f3    <= lsu.funct3_i;
              r_off   <= lsu.addr_i[1:0];
              r_cnt   <= 8'd0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        c_BUS: begin
          if (r_cyc) begin
            if (lsu.bus_ack_i) begin
              r_cyc  <= 1'b0;
              r_done <= 1'b1;
              if (!r_we) r_mem <= w_load;
            end else if (r_cnt == c_TO_LAST) begin
              r_cyc <= 1'b0;
              r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign lsu.busy_o    = (r_state != c_IDLE);
  assign lsu.done_o    = r_done;
  assign lsu.err_o     = r_err;
  assign lsu.mem_o     = r_mem;
  assign lsu.bus_cyc_o = r_cyc;
  assign lsu.bus_stb_o = r_cyc;
  assign lsu.bus_we_o  = r_we;
  assign lsu.bus_adr_o = r_adr;
  assign lsu.bus_sel_o = r_sel;
  assign lsu.bus_dat_o = r_dat;

endmodule
`default_nettype wire
